// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Round-robin arbiter that shares one single-port RAM between two Avalon-MM
// pipelined masters: port A (CPU data master) and port B (VGA text fetch).
// Read data is steered back to the requester through a tag pipe whose depth
// matches the RAM read latency.

// Per-port read-return lane: qualifies the shared RAM read bus with this port's tag.
module onchip_mem_arbiter_rsp #(
    parameter int   DATA_W = 32,
    parameter logic PORT   = 1'b0
) (
    input  logic              tag_vld,
    input  logic              tag_port,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              readdatavalid,
    output logic [DATA_W-1:0] readdata
);

    // Valid comes straight off the tag flops; data is forced to zero when not ours.
    always_comb begin
        readdatavalid = tag_vld && (tag_port == PORT);
        readdata      = readdatavalid ? mem_readdata : '0;
    end

endmodule

module onchip_mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // port A
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic                  a_waitrequest,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    // port B
    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic                  b_waitrequest,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    // RAM s1
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int   BE_W   = DATA_W / 8;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic vld;
        logic port;
    } tag_t;

    req_t [1:0]             req;
    req_t                   sel;
    logic [1:0]             req_v;
    logic [1:0]             gnt;
    logic [1:0]             wait_v;
    logic [1:0]             rdv;
    logic [1:0][DATA_W-1:0] rdata;
    logic                   last_gnt_q, last_gnt_d;
    tag_t [RD_LAT-1:0]      tag_q, tag_d;

    // Index 0 is port A, index 1 is port B throughout.
    assign req[0] = '{addr: a_address, be: a_byteenable, rd: a_read, wr: a_write, wdata: a_writedata};
    assign req[1] = '{addr: b_address, be: b_byteenable, rd: b_read, wr: b_write, wdata: b_writedata};

    // Grant: a lone requester wins; on contention the port that did not win last time wins.
    // Nothing is granted while reset is held so the RAM sees no access.
    always_comb begin
        gnt = 2'b00;
        for (int p = 0; p < 2; p++) req_v[p] = req[p].rd | req[p].wr;
        if (reset_n) begin
            if (req_v[0] && (!req_v[1] || last_gnt_q == PORT_B)) gnt[0] = 1'b1;
            else if (req_v[1])                                    gnt[1] = 1'b1;
        end
        for (int p = 0; p < 2; p++) wait_v[p] = !reset_n || (req_v[p] && !gnt[p]);
        last_gnt_d = (|gnt) ? gnt[1] : last_gnt_q;
    end

    // RAM side: forward the granted request, drive zeros when idle.
    always_comb begin
        sel            = gnt[1] ? req[1] : req[0];
        mem_chipselect = |gnt;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (|gnt) begin
            mem_write      = sel.wr;
            mem_address    = sel.addr;
            mem_byteenable = sel.be;
            mem_writedata  = sel.wdata;
        end
        mem_clken = reset_n;
    end

    // Tag pipe: a read+write counts as a write, so only pure reads push a valid tag.
    always_comb begin
        tag_d[0].vld  = (|gnt) && sel.rd && !sel.wr;
        tag_d[0].port = gnt[1];
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    // State: round-robin pointer and tag pipe; reset drops any reads in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= PORT_B;
            tag_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            tag_q      <= tag_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rsp
        onchip_mem_arbiter_rsp #(
            .DATA_W (DATA_W),
            .PORT   (1'(p))
        ) u_rsp (
            .tag_vld       (tag_q[RD_LAT-1].vld),
            .tag_port      (tag_q[RD_LAT-1].port),
            .mem_readdata  (mem_readdata),
            .readdatavalid (rdv[p]),
            .readdata      (rdata[p])
        );
    end

    assign a_waitrequest   = wait_v[0];
    assign b_waitrequest   = wait_v[1];
    assign a_readdatavalid = rdv[0];
    assign b_readdatavalid = rdv[1];
    assign a_readdata      = rdata[0];
    assign b_readdata      = rdata[1];

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: one RD_LAT=1 instance with a RAM model and a
// scoreboard on both ports, plus one RD_LAT=3 instance for back-to-back reads.
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- RD_LAT = 1 instance ----------------
    logic [1:0]  a_address, b_address;
    logic [3:0]  a_byteenable, b_byteenable;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_writedata, b_writedata;
    logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic [31:0] a_readdata, b_readdata;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM model: address registered, one cycle to data
    logic [31:0] ram1 [4];
    logic [31:0] q1;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram1[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end else begin
                q1 <= ram1[mem_address];
            end
        end
    end
    assign mem_readdata = q1;

    // ---------------- RD_LAT = 3 instance (port A only) ----------------
    logic [1:0]  c_address;
    logic        c_read;
    logic        c_waitrequest, c_readdatavalid, cb_waitrequest, cb_readdatavalid;
    logic [31:0] c_readdata, cb_readdata;
    logic [1:0]  m3_address;
    logic [3:0]  m3_byteenable;
    logic        m3_chipselect, m3_write, m3_clken;
    logic [31:0] m3_writedata, m3_readdata;

    onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .a_address(c_address), .a_byteenable(4'hF), .a_read(c_read), .a_write(1'b0),
        .a_writedata(32'h0), .a_waitrequest(c_waitrequest), .a_readdata(c_readdata),
        .a_readdatavalid(c_readdatavalid),
        .b_address(2'd0), .b_byteenable(4'h0), .b_read(1'b0), .b_write(1'b0),
        .b_writedata(32'h0), .b_waitrequest(cb_waitrequest), .b_readdata(cb_readdata),
        .b_readdatavalid(cb_readdatavalid),
        .mem_address(m3_address), .mem_byteenable(m3_byteenable), .mem_chipselect(m3_chipselect),
        .mem_write(m3_write), .mem_writedata(m3_writedata), .mem_clken(m3_clken),
        .mem_readdata(m3_readdata)
    );

    logic [31:0] ram3 [4];
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (m3_clken) begin
            p3[0] <= ram3[m3_address];
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign m3_readdata = p3[2];

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$], qb[$], q3[$];
    logic [31:0] sh [4];
    bit          m_last = 1'b1;     // 1 = B won last, so A wins the next contest
    bit          acc_a = 1'b0, acc_b = 1'b0;
    logic [31:0] a_last, b_last, c_last;
    int          na_rdv = 0, nb_rdv = 0, n3_rdv = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        logic ra, rb, ga, gb;
        if (!reset_n) begin
            qa.delete(); qb.delete(); q3.delete();
            m_last = 1'b1; acc_a = 1'b0; acc_b = 1'b0;
            chk("rst_a_wait", a_waitrequest, 1);
            chk("rst_b_wait", b_waitrequest, 1);
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_mwr", mem_write, 0);
            chk("rst_clken", mem_clken, 0);
            chk("rst_a_rdv", a_readdatavalid, 0);
            chk("rst_b_rdv", b_readdatavalid, 0);
            chk("rst_a_rdat", a_readdata, 0);
            chk("rst_b_rdat", b_readdata, 0);
            chk("rst_c_rdv", c_readdatavalid, 0);
        end else begin
            // returns first: anything due now was pushed in an earlier cycle
            if (a_readdatavalid) begin
                na_rdv++;
                if (qa.size() == 0) chk("a_rdv_unexpected", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_rdata", a_readdata, e.data);
                    chk("a_rdlat", cyc, e.due);
                    a_last = a_readdata;
                end
            end else chk("a_rdata_idle", a_readdata, 0);
            if (b_readdatavalid) begin
                nb_rdv++;
                if (qb.size() == 0) chk("b_rdv_unexpected", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_rdata", b_readdata, e.data);
                    chk("b_rdlat", cyc, e.due);
                    b_last = b_readdata;
                end
            end else chk("b_rdata_idle", b_readdata, 0);

            ra = a_read | a_write;
            rb = b_read | b_write;
            ga = ra && (!rb || m_last);
            gb = rb && !ga;
            chk("a_wait", a_waitrequest, ra && !ga);
            chk("b_wait", b_waitrequest, rb && !gb);
            chk("mem_cs", mem_chipselect, ga | gb);
            chk("mem_clken", mem_clken, 1);
            chk("mem_wr", mem_write, ga ? a_write : (gb ? b_write : 1'b0));
            if (ga) begin
                chk("mem_addr_a", mem_address, a_address);
                if (a_write) begin
                    chk("mem_wdata_a", mem_writedata, a_writedata);
                    chk("mem_be_a", mem_byteenable, a_byteenable);
                    sh[a_address] = merge(sh[a_address], a_writedata, a_byteenable);
                end else begin
                    e.due = cyc + 1; e.data = sh[a_address]; qa.push_back(e);
                end
                m_last = 1'b0;
            end
            if (gb) begin
                chk("mem_addr_b", mem_address, b_address);
                if (b_write) begin
                    chk("mem_wdata_b", mem_writedata, b_writedata);
                    chk("mem_be_b", mem_byteenable, b_byteenable);
                    sh[b_address] = merge(sh[b_address], b_writedata, b_byteenable);
                end else begin
                    e.due = cyc + 1; e.data = sh[b_address]; qb.push_back(e);
                end
                m_last = 1'b1;
            end
            acc_a = ga;
            acc_b = gb;

            // RD_LAT=3 instance: port B idle, so every A read is accepted at once
            if (c_readdatavalid) begin
                n3_rdv++;
                if (q3.size() == 0) chk("c_rdv_unexpected", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("c_rdata", c_readdata, e.data);
                    chk("c_rdlat", cyc, e.due);
                    c_last = c_readdata;
                end
            end
            if (c_read) begin
                chk("c_wait", c_waitrequest, 0);
                e.due = cyc + 3; e.data = ram3[c_address]; q3.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one request on a port and hold it until the model says it was granted.
    task automatic xfer(input bit p, input logic rd, input logic wr, input logic [1:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
        int n;
        bit acc;
        if (!p) begin
            a_read = rd; a_write = wr; a_address = ad; a_writedata = wd; a_byteenable = be;
        end else begin
            b_read = rd; b_write = wr; b_address = ad; b_writedata = wd; b_byteenable = be;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            acc = p ? acc_b : acc_a;
        end while (!acc && n < 20);
        chk("xfer_accepted", acc, 1);
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int ca, cb, n0;
        a_read = 0; a_write = 0; a_address = 0; a_writedata = 0; a_byteenable = 0;
        b_read = 0; b_write = 0; b_address = 0; b_writedata = 0; b_byteenable = 0;
        c_read = 0; c_address = 0;
        for (int i = 0; i < 4; i++) ram3[i] = 32'h3000_0000 + i;
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // write then read back on A
        xfer(0, 0, 1, 2, 32'hDEADBEEF, 4'hF);
        xfer(0, 1, 0, 2, 32'h0, 4'hF);
        idle(3);
        chk("t1_a_data", a_last, 32'hDEADBEEF);
        chk("t1_b_no_rdv", nb_rdv, 0);

        // partial write on B: byte lanes 0 and 2 replaced
        xfer(0, 0, 1, 1, 32'h11223344, 4'hF);
        xfer(1, 0, 1, 1, 32'hAABBCCDD, 4'b0101);
        xfer(1, 1, 0, 1, 32'h0, 4'hF);
        idle(3);
        chk("t2_partial", b_last, 32'h11BB33DD);

        // fill remaining words
        xfer(0, 0, 1, 0, 32'hA0A0A0A0, 4'hF);
        xfer(1, 0, 1, 3, 32'hB3B3B3B3, 4'hF);
        idle(2);

        // contention from reset: A first, then strict alternation
        pulse_reset();
        ca = 0; cb = 0;
        n0 = na_rdv + nb_rdv;
        for (int i = 0; i < 6; i++) begin
            a_read = 1; b_read = 1;
            a_address = 2'(ca); b_address = 2'(3 - cb);
            @(posedge clk); #1;
            chk("cont_gnt_a", acc_a, (i % 2) == 0);
            chk("cont_gnt_b", acc_b, (i % 2) == 1);
            if (acc_a) ca++;
            if (acc_b) cb++;
        end
        a_read = 0; b_read = 0;
        idle(3);
        chk("cont_a_cnt", ca, 3);
        chk("cont_b_cnt", cb, 3);
        chk("cont_rdv_cnt", na_rdv + nb_rdv - n0, 6);
        chk("cont_a_last", a_last, 32'hDEADBEEF);   // A read 0,1,2
        chk("cont_b_last", b_last, 32'h11BB33DD);   // B read 3,2,1

        // read+write together is a write: no return pulse
        n0 = na_rdv;
        xfer(0, 1, 1, 3, 32'h5, 4'hF);
        idle(3);
        chk("rw_no_rdv", na_rdv - n0, 0);
        xfer(0, 1, 0, 3, 32'h0, 4'hF);
        idle(3);
        chk("rw_data", a_last, 32'h5);

        // reset while a B read is in flight
        b_read = 1; b_address = 0;
        @(posedge clk); #1;
        reset_n = 0; b_read = 0;
        @(posedge clk); #1;
        reset_n = 1;
        n0 = nb_rdv;
        idle(3);
        chk("rst_drop", nb_rdv - n0, 0);
        a_read = 1; b_read = 1; a_address = 0; b_address = 0;
        @(posedge clk); #1;
        chk("rst_first_a", acc_a, 1);
        chk("rst_first_not_b", acc_b, 0);
        @(posedge clk); #1;
        chk("rst_second_b", acc_b, 1);
        a_read = 0; b_read = 0;
        idle(3);

        // RD_LAT=3: four back-to-back reads
        n0 = n3_rdv;
        for (int i = 0; i < 4; i++) begin
            c_read = 1; c_address = 2'(i);
            @(posedge clk); #1;
        end
        c_read = 0;
        idle(6);
        chk("lat3_cnt", n3_rdv - n0, 4);
        chk("lat3_last", c_last, 32'h3000_0003);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("q3_empty", q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
